uart_tx_stream: RTL and testbench
=================================

Name: uart_tx_stream

Overview:
Parametrised, buffered UART transmitter for the host link.
- Accepts bytes over a valid/ready stream into an internal FIFO.
- Serialises each byte as start, data (LSB first), optional parity, then stop bit(s).
- Every bit lasts exactly OVERSAMPLE baud_tick pulses.
- Successor to the single-shot transmitter: adds configurable data width, configurable stop bits, buffering, back-to-back frames and flow control.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud_tick pulses per bit; legal range 2..64.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- baud_tick  in  1  single-cycle oversample strobe
- s_valid  in  1  producer has data
- s_ready  out  1  FIFO can accept; equals (fifo_count < FIFO_DEPTH)
- s_data  in  DATA_BITS  byte to send; captured on s_valid && s_ready
- tx  out  1  serial line; registered; idles high
- busy  out  1  (state != IDLE) || (fifo_count != 0)
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently held
- parity_odd  in  1  only present with UART_TX_PARITY_EN: 1 = odd parity, 0 = even

Behaviour:
- Reset (async, any time, including mid-frame): tx=1, state=IDLE, FIFO emptied (fifo_count=0, s_ready=1, busy=0), tick_cnt=0, bit_idx=0.
- FIFO:
  - Push on clk edge when s_valid && s_ready.
  - Pop when the FSM loads a frame.
  - Simultaneous push and pop: count unchanged; both take effect.
  - s_valid while full: ignored, data dropped at the source by the handshake (s_ready=0).
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. The FSM advances only on clk edges where baud_tick=1.
- IDLE:
  - tx=1.
  - On baud_tick with FIFO non-empty: pop head into shift register, tx<=0, tick_cnt<=OVERSAMPLE-1, go to START.
  - The start bit begins on that same edge. The FIFO is not a pass-through, so an entry pushed on this edge is not visible until the next tick.
- Each bit state, per baud_tick:
  - If tick_cnt != 0: tick_cnt decrements and tx holds.
  - If tick_cnt == 0: load the next bit onto tx and set tick_cnt<=OVERSAMPLE-1.
  - Each bit is therefore held for exactly OVERSAMPLE ticks.
- START -> DATA with tx=data[0].
- DATA: bit_idx increments after each bit. After bit DATA_BITS-1, go to PARITY (macro on) or STOP (macro off).
- PARITY -> STOP with tx=1.
- STOP: hold tx=1 for STOP_BITS*OVERSAMPLE ticks total, tracked with a stop counter. At the end:
  - FIFO non-empty: pop, tx<=0, go directly to START (zero idle gap).
  - FIFO empty: go to IDLE.
- Frame length in ticks: (1 + DATA_BITS + P + STOP_BITS) * OVERSAMPLE, where P=1 if parity is enabled, else 0.
- baud_tick low: no FSM change. FIFO push is still accepted.
- Counter widths are explicit ($clog2-based); no integer-width state registers.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - Adds the parity_odd port and the PARITY state.
  - Parity bit = ^data XOR parity_odd, computed over all DATA_BITS.
  - parity_odd is sampled when the frame is popped and held for the whole frame.
- Undefined: no parity_odd port, no PARITY state, DATA goes directly to STOP.

Test Plan:
- Reset, then push 0xA5 (DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1, no parity):
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 ticks, frame 160 ticks.
  - busy=1 throughout, busy=0 after the stop bit.
- Push 0x11, 0x22, 0x33 in consecutive cycles:
  - fifo_count reaches 3.
  - Three frames sent with no idle ticks between the stop bit and the next start bit.
  - Decoded bytes in order 0x11, 0x22, 0x33.
- Hold s_valid with baud_tick=0 for FIFO_DEPTH+2 cycles:
  - s_ready drops after 4 pushes; fifo_count=4; extra data is not stored.
- Push at the same edge as a pop: fifo_count unchanged; both bytes appear on tx in order.
- Assert rst during DATA bit 3 of 0xFF with 2 entries queued:
  - tx=1, fifo_count=0, busy=0 immediately.
  - No further frames are sent.
- With UART_TX_PARITY_EN and STOP_BITS=2, parity_odd=0, push 0x07:
  - Parity bit 1.
  - Stop high for 32 ticks.
  - Frame length (1+8+1+2)*16 = 192 ticks.

Source files
------------

// File: rtl/uart_tx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_stream
// Brief    : Buffered UART transmitter. Bytes enter a FIFO over a valid/ready
//            stream and are sent as start, data (LSB first), optional parity
//            and stop bit(s), each bit lasting OVERSAMPLE baud_tick pulses.
//            Optional parity is enabled by defining UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_stream #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef UART_TX_PARITY_EN
  ,
  input  logic                          parity_odd
`endif
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_TICK_W = $clog2(OVERSAMPLE);
  localparam int c_BIT_W  = $clog2(DATA_BITS);
  localparam logic [c_TICK_W-1:0] c_TICK_MAX  = c_TICK_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_BITS - 1);
  localparam logic                c_STOP_INIT = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0]  r_wr_ptr;
  logic [c_ADDR_W-1:0]  r_rd_ptr;
  logic [c_ADDR_W:0]    r_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_nonempty;
  logic [DATA_BITS-1:0] w_head;

  // Serialiser state
  state_t               r_state,  w_state_n;
  logic                 r_tx,     w_tx_n;
  logic [c_TICK_W-1:0]  r_tick,   w_tick_n;
  logic [c_BIT_W-1:0]   r_bit,    w_bit_n;
  logic [DATA_BITS-1:0] r_shift,  w_shift_n;
  logic                 r_stop,   w_stop_n;
  logic                 w_load;
`ifdef UART_TX_PARITY_EN
  logic                 r_par,    w_par_n;
`endif

  assign s_ready    = (r_count < (c_ADDR_W+1)'(FIFO_DEPTH));
  assign w_push     = s_valid && s_ready;
  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE) || w_nonempty;

  // FIFO payload write; storage itself needs no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and occupancy; a push and pop on the same edge cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (c_ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Serialiser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tx    <= 1'b1;
      r_tick  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_stop  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_tx    <= w_tx_n;
      r_tick  <= w_tick_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_stop  <= w_stop_n;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_n;
`endif
    end
  end

  // Next-state logic: advances only on baud_tick; a frame load starts the
  // start bit on the same edge, either from IDLE or straight out of STOP
  always_comb begin
    w_state_n = r_state;
    w_tx_n    = r_tx;
    w_tick_n  = r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_stop_n  = r_stop;
    w_load    = 1'b0;
    w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_par_n   = r_par;
`endif
    if (baud_tick) begin
      if (r_state == ST_IDLE) begin
        w_tx_n = 1'b1;
        w_load = w_nonempty;
      end else if (r_tick != '0) begin
        w_tick_n = r_tick - c_TICK_W'(1);
      end else begin
        w_tick_n = c_TICK_MAX;
        case (r_state)
          ST_START: begin
            w_tx_n    = r_shift[0];
            w_shift_n = r_shift >> 1;
            w_bit_n   = '0;
            w_state_n = ST_DATA;
          end
          ST_DATA: begin
            if (r_bit == c_BIT_LAST) begin
              w_bit_n = '0;
`ifdef UART_TX_PARITY_EN
              w_tx_n    = r_par;
              w_state_n = ST_PARITY;
`else
              w_tx_n    = 1'b1;
              w_stop_n  = c_STOP_INIT;
              w_state_n = ST_STOP;
`endif
            end else begin
              w_tx_n    = r_shift[0];
              w_shift_n = r_shift >> 1;
              w_bit_n   = r_bit + c_BIT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          ST_PARITY: begin
            w_tx_n    = 1'b1;
            w_stop_n  = c_STOP_INIT;
            w_state_n = ST_STOP;
          end
`endif
          ST_STOP: begin
            if (r_stop != 1'b0) begin
              w_stop_n = 1'b0;
            end else if (w_nonempty) begin
              w_load = 1'b1;
            end else begin
              w_tick_n  = '0;
              w_state_n = ST_IDLE;
            end
          end
          default: begin
            w_tx_n    = 1'b1;
            w_tick_n  = '0;
            w_state_n = ST_IDLE;
          end
        endcase
      end
      if (w_load) begin
        w_pop     = 1'b1;
        w_shift_n = w_head;
        w_tx_n    = 1'b0;
        w_tick_n  = c_TICK_MAX;
        w_bit_n   = '0;
        w_state_n = ST_START;
`ifdef UART_TX_PARITY_EN
        w_par_n   = (^w_head) ^ parity_odd;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_stream
// Brief    : Scoreboard bench for uart_tx_stream. Stimulus queues expected
//            bytes; a line monitor decodes tx per baud tick and compares.
//            Covers the parity variant when UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_stream;

  localparam int DB = 8;
  localparam int OV = 16;
  localparam int FD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int SB = 2;
  localparam int PB = 1;
`else
  localparam int SB = 1;
  localparam int PB = 0;
`endif
  localparam int NB          = 1 + DB + PB + SB;
  localparam int FRAME_TICKS = NB * OV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick_gen = 1'b0;
  logic tick_force = 1'b0;
  logic tick_en = 1'b0;
  logic baud_tick;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [DB-1:0] s_data = '0;
  logic tx;
  logic busy;
  logic [$clog2(FD):0] fifo_count;
`ifdef UART_TX_PARITY_EN
  logic parity_odd = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [DB-1:0] exp_q[$];
  int start_log[$];
  int tick_no = 0;
  int frames_done = 0;
  logic [NB-1:0] last_bits = '0;

  assign baud_tick = tick_gen | tick_force;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .DATA_BITS (DB),
    .OVERSAMPLE(OV),
    .STOP_BITS (SB),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
`ifdef UART_TX_PARITY_EN
    ,
    .parity_odd(parity_odd)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard side: one decoded frame against the head of the queue
  task automatic frame_done(input logic [NB-1:0] fb, input logic herr);
    logic [DB-1:0] data;
    logic [DB-1:0] exp;
    data = fb[DB:1];
    check("start_bit", int'(fb[0]), 0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_frame: got 0x%0h, required no frame", data);
      exp = data;
    end else begin
      exp = exp_q.pop_front();
      check("data_byte", int'(data), int'(exp));
    end
`ifdef UART_TX_PARITY_EN
    check("parity_bit", int'(fb[DB+1]), int'((^exp) ^ parity_odd));
`endif
    check("stop_bits", int'(fb[NB-1:NB-SB]), (1 << SB) - 1);
    check("bit_hold", int'(herr), 0);
    last_bits = fb;
    frames_done++;
  endtask

  // Baud tick source: one pulse every fourth clock while enabled
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      tick_gen = tick_en && (div == 3);
      div = (div + 1) % 4;
    end
  end

  // Line monitor: samples tx after every tick edge and decodes frames
  initial begin
    int samp;
    logic active;
    logic cur;
    logic herr;
    logic [NB-1:0] fb;
    samp = 0; active = 1'b0; cur = 1'b1; herr = 1'b0; fb = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        active = 1'b0;
      end else if (baud_tick) begin
        tick_no++;
        #1;
        if (!active && tx == 1'b0) begin
          active = 1'b1;
          samp = 0;
          herr = 1'b0;
          start_log.push_back(tick_no);
        end
        if (active) begin
          if (samp % OV == 0) begin
            cur = tx;
            fb[samp / OV] = tx;
          end else if (tx !== cur) begin
            herr = 1'b1;
          end
          samp++;
          if (samp == FRAME_TICKS) begin
            active = 1'b0;
            frame_done(fb, herr);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [DB-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    cyc();
    s_valid = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic wait_frames(input int target, input int maxc, output int low);
    low = 0;
    for (int i = 0; i < maxc && frames_done < target; i++) begin
      cyc();
      if (!busy) low++;
    end
    check("frames_seen", frames_done, target);
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc && busy; i++) cyc();
    check("idle_reached", int'(busy), 0);
  endtask

  initial begin
    int low;
    int t0;
    int n0;
    int fd0;
    int tx_low;

    // Reset state
    rst = 1'b1;
    repeat (3) cyc();
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(s_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    cyc();

    // Single frame 0xA5
    tick_en = 1'b1;
    push(8'hA5);
    wait_frames(1, 2000, low);
    check("t1_busy_low", low, 0);
`ifndef UART_TX_PARITY_EN
    check("t1_bits", int'(last_bits), 'b1101001010);
`endif
    t0 = start_log[start_log.size()-1];
    wait_idle(200);
    check("t1_frame_len", tick_no - t0, FRAME_TICKS);
    check("t1_tx_idle", int'(tx), 1);

    // Three-byte burst, back to back
    tick_en = 1'b0;
    cyc();
    n0 = start_log.size();
    fd0 = frames_done;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    check("t2_count", int'(fifo_count), 3);
    tick_en = 1'b1;
    wait_frames(fd0 + 3, 6000, low);
    check("t2_gap1", start_log[n0+1] - start_log[n0], FRAME_TICKS);
    check("t2_gap2", start_log[n0+2] - start_log[n0+1], FRAME_TICKS);
    wait_idle(200);

    // Fill with ticks stopped: only FIFO_DEPTH entries stored
    tick_en = 1'b0;
    cyc();
    fd0 = frames_done;
    s_valid = 1'b1;
    for (int i = 0; i < FD + 2; i++) begin
      s_data = DB'(8'h40 + i);
      cyc();
      if (i < FD) exp_q.push_back(DB'(8'h40 + i));
      check("t3_ready", int'(s_ready), (i + 1 < FD) ? 1 : 0);
      check("t3_count", int'(fifo_count), (i + 1 < FD) ? i + 1 : FD);
    end
    s_valid = 1'b0;
    tick_en = 1'b1;
    wait_frames(fd0 + FD, 8000, low);
    wait_idle(200);
    check("t3_leftover", exp_q.size(), 0);
    check("t3_frames", frames_done, fd0 + FD);

    // Push on the same edge as the pop from IDLE
    tick_en = 1'b0;
    cyc();
    fd0 = frames_done;
    n0 = start_log.size();
    push(8'h3C);
    s_valid = 1'b1;
    s_data = 8'h5A;
    tick_force = 1'b1;
    cyc();
    s_valid = 1'b0;
    tick_force = 1'b0;
    exp_q.push_back(8'h5A);
    check("t4_count", int'(fifo_count), 1);
    check("t4_start", int'(tx), 0);
    tick_en = 1'b1;
    wait_frames(fd0 + 2, 4000, low);
    check("t4_gap", start_log[n0+1] - start_log[n0], FRAME_TICKS);
    wait_idle(200);

    // Reset during data bit 3 of 0xFF with two entries queued
    tick_en = 1'b0;
    cyc();
    n0 = start_log.size();
    push(8'hFF);
    push(8'h01);
    push(8'h02);
    tick_en = 1'b1;
    for (int i = 0; i < 100 && start_log.size() == n0; i++) cyc();
    check("t5_started", start_log.size(), n0 + 1);
    t0 = (start_log.size() > n0) ? start_log[n0] : tick_no;
    for (int i = 0; i < 1000 && tick_no < t0 + 4 * OV + 6; i++) cyc();
    check("t5_queued", int'(fifo_count), 2);
    rst = 1'b1;
    #1;
    check("t5_tx", int'(tx), 1);
    check("t5_count", int'(fifo_count), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_ready", int'(s_ready), 1);
    exp_q.delete();
    repeat (2) cyc();
    rst = 1'b0;
    n0 = start_log.size();
    tx_low = 0;
    for (int i = 0; i < 800; i++) begin
      cyc();
      if (!tx) tx_low++;
    end
    check("t5_no_frames", start_log.size(), n0);
    check("t5_tx_low", tx_low, 0);

`ifdef UART_TX_PARITY_EN
    // Even parity over 0x07 with two stop bits
    fd0 = frames_done;
    push(8'h07);
    wait_frames(fd0 + 1, 3000, low);
    check("t6_parity", int'(last_bits[DB+1]), 1);
    check("t6_stop", int'(last_bits[NB-1:NB-2]), 3);
    t0 = start_log[start_log.size()-1];
    wait_idle(200);
    check("t6_frame_len", tick_no - t0, 192);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
